vga_bg_loader: RTL and testbench
================================

VGA_BG_LOADER -- requirements
Module: vga_bg_loader

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on posedge clk.
REQ-003 SHALL have port v_active, input, 1, vertical active-region flag from the VGA timing generator.
REQ-004 SHALL have port in_data, input, 8, command/data byte.
REQ-005 SHALL have port in_valid, input, 1, in_data valid.
REQ-006 SHALL have port in_ready, output, 1, loader accepts a byte; a transfer occurs when in_valid && in_ready on a clk edge.
REQ-007 SHALL have ports bg_pixels_0 and bg_pixels_1, output, 32 each, live background pixel words, 16 pixels x 2 bits, pixel n at bits [2n+1:2n].
REQ-008 SHALL have ports bg_size_0 and bg_size_1, output, 6 each, live pixel-width-minus-one per half.
REQ-009 SHALL have port pending, output, 1, shadow holds at least one uncommitted write.

Function
REQ-010 SHALL parse packets of one header byte followed by data bytes; header[1:0] selects target: 0 pixels_0, 1 pixels_1, 2 size_0, 3 size_1.
REQ-011 SHALL treat a header with header[7:2] != 0 as invalid: byte consumed, no write, FSM stays in HDR.
REQ-012 SHALL use FSM states HDR and DATA; valid header -> DATA, byte counter cleared; DATA returns to HDR on the final data byte.
REQ-013 SHALL take 4 data bytes, LSB byte first, for pixel targets, and 1 data byte for size targets, using bits [5:0] and ignoring bits [7:6].
REQ-014 SHALL update the selected shadow register and set the dirty flag on the clock edge that accepts the final data byte; partial words never reach the shadow register.
REQ-015 SHALL hold in_ready = 1 in every cycle after reset; the loader never back-pressures.
REQ-016 SHALL commit on vblank start, defined as v_active 1 in the previous cycle and 0 in the current cycle.
REQ-017 SHALL, on commit, copy all four shadow registers to the outputs on that edge and clear dirty; a commit with dirty = 0 leaves the outputs unchanged.
REQ-018 SHALL, when commit and a final data byte coincide, commit the shadow values from before that byte; the new write lands in the shadow and dirty stays 1 (set beats clear).
REQ-019 SHALL keep outputs stable during the whole of v_active = 1; no partial-frame updates.
REQ-020 SHALL drive pending = dirty as a registered value.
REQ-021 SHALL let in_valid = 0 cycles between bytes stall the FSM with no timeout.

Reset
REQ-022 SHALL, while rst_n = 0 at a clk edge, clear all outputs, shadows, dirty, the byte counter, and the previous-v_active register to 0, and set the FSM to HDR.
REQ-023 SHALL, on reset in mid-packet, discard the partial packet; the first byte after reset is parsed as a header.
REQ-024 SHALL drive in_ready = 0 during reset and 1 from the first edge with rst_n = 1.

Configuration
REQ-025 SHALL, with VGA_BG_LOADER_VSYNC_COMMIT_EN defined, use the vblank commit of REQ-016 to REQ-019.
REQ-026 SHALL, without VGA_BG_LOADER_VSYNC_COMMIT_EN, commit one cycle after the final data byte regardless of v_active; pending is high for exactly that one cycle.

Structure
REQ-027 SHALL place the target codes (TGT_PIX0..TGT_SIZE1), byte counts per target, and the FSM state enum in the shared package vga_pkg.
REQ-028 SHALL use one sub-module, vga_byte_packer, which shifts 8-bit bytes into a 32-bit word and flags word completion; no other sub-modules.

Verification
REQ-029 SHALL cover: v_active = 1, send 0x00,0x44,0x33,0x22,0x11 -> pending = 1, bg_pixels_0 = 0; drop v_active -> next edge bg_pixels_0 = 0x11223344, pending = 0.
REQ-030 SHALL cover: send 0x03,0xC5 then a vblank -> bg_size_1 = 0x05; the other outputs are unchanged.
REQ-031 SHALL cover: header 0x84 -> no write, pending stays 0; a following 0x02,0x07 plus vblank -> bg_size_0 = 7.
REQ-032 SHALL cover: final byte of 0x01,0xAA,0xBB,0xCC,0xDD on the vblank-start edge -> bg_pixels_1 unchanged, pending = 1; next vblank -> 0xDDCCBBAA.
REQ-033 SHALL cover: rst_n = 0 after 2 data bytes of a pixel packet -> all outputs 0; then 0x02,0x09 plus vblank -> bg_size_0 = 9.
REQ-034 SHALL cover: without the macro, send 0x00,0x04,0x03,0x02,0x01 with v_active = 1 -> bg_pixels_0 = 0x01020304 one cycle after the final byte.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// =============================================================================
// vga_pkg : target codes, per-target byte counts and FSM states for the loader
// Revision 1.0
// =============================================================================
package vga_pkg;

   localparam logic [1:0] TGT_PIX0  = 2'd0;
   localparam logic [1:0] TGT_PIX1  = 2'd1;
   localparam logic [1:0] TGT_SIZE0 = 2'd2;
   localparam logic [1:0] TGT_SIZE1 = 2'd3;

   localparam int PIX_BYTES  = 4;
   localparam int SIZE_BYTES = 1;

   typedef enum logic [0:0] {
      ST_HDR  = 1'b0,
      ST_DATA = 1'b1
   } state_e;

   // Index of the final data byte of a packet for the given target
   function automatic logic [1:0] last_byte_idx(input logic [1:0] tgt);
      return tgt[1] ? 2'(SIZE_BYTES - 1) : 2'(PIX_BYTES - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_bg_loader_if.sv
`default_nettype none
// =============================================================================
// vga_bg_loader_if : byte-stream valid/ready channel into the background loader
// Revision 1.0
// =============================================================================
interface vga_bg_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/vga_byte_packer.sv
`default_nettype none
// =============================================================================
// vga_byte_packer : shifts bytes LSB-first into a 32-bit word, flags last byte
// Revision 1.0
// =============================================================================
module vga_byte_packer (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        clear_i,
   input  wire logic        push_i,
   input  wire logic [7:0]  byte_i,
   input  wire logic [1:0]  last_idx_i,
   output logic      [31:0] word_o,
   output logic             done_o
);
   logic [31:0] word_q;
   logic [1:0]  cnt_q;

   // word_o already includes the byte being pushed so the final word is usable
   // on the same edge that accepts it
   assign word_o = {byte_i, word_q[31:8]};
   assign done_o = push_i && (cnt_q == last_idx_i);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q <= 32'd0;
         cnt_q  <= 2'd0;
      end else if (clear_i) begin
         word_q <= 32'd0;
         cnt_q  <= 2'd0;
      end else if (push_i) begin
         word_q <= word_o;
         cnt_q  <= cnt_q + 2'd1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/vga_bg_loader.sv
`default_nettype none
// =============================================================================
// vga_bg_loader : packet parser writing shadow background registers, committed
// to live outputs on vblank start (VGA_BG_LOADER_VSYNC_COMMIT_EN) or one cycle
// after each write (macro undefined).
// Revision 1.0
// =============================================================================
module vga_bg_loader
   import vga_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        v_active,
   vga_bg_loader_if.slave   bus,
   output logic      [31:0] bg_pixels_0,
   output logic      [31:0] bg_pixels_1,
   output logic      [5:0]  bg_size_0,
   output logic      [5:0]  bg_size_1,
   output logic             pending
);
   state_e      state_q, state_d;
   logic [1:0]  tgt_q;
   logic        ready_q, vprev_q, dirty_q, dirty_d;
   logic [31:0] shpix0_q, shpix1_q, pix0_q, pix1_q;
   logic [5:0]  shsize0_q, shsize1_q, size0_q, size1_q;
   logic        w_fire, w_hdr_ok, w_clear, w_push, w_done, w_commit;
   logic [31:0] w_word;

   assign w_fire   = bus.in_valid && ready_q;
   assign w_hdr_ok = (bus.in_data[7:2] == 6'd0);

   vga_byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (w_clear),
      .push_i     (w_push),
      .byte_i     (bus.in_data),
      .last_idx_i (last_byte_idx(tgt_q)),
      .word_o     (w_word),
      .done_o     (w_done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_HDR;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HDR:  if (w_fire && w_hdr_ok) state_d = ST_DATA;
         ST_DATA: if (w_done)             state_d = ST_HDR;
         default:                         state_d = ST_HDR;
      endcase
   end

   always_comb begin
      w_clear = 1'b0;
      w_push  = 1'b0;
      case (state_q)
         ST_HDR:  w_clear = w_fire && w_hdr_ok;
         ST_DATA: w_push  = w_fire;
         default: ;
      endcase
   end

`ifdef VGA_BG_LOADER_VSYNC_COMMIT_EN
   assign w_commit = dirty_q && vprev_q && !v_active;
`else
   logic w_unused_vprev;
   assign w_unused_vprev = vprev_q;
   assign w_commit       = dirty_q;
`endif

   // A write landing on the commit edge keeps dirty set so it is not lost
   always_comb begin
      dirty_d = dirty_q;
      if (w_commit) dirty_d = 1'b0;
      if (w_done)   dirty_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready_q   <= 1'b0;
         vprev_q   <= 1'b0;
         dirty_q   <= 1'b0;
         tgt_q     <= 2'd0;
         shpix0_q  <= 32'd0;
         shpix1_q  <= 32'd0;
         shsize0_q <= 6'd0;
         shsize1_q <= 6'd0;
         pix0_q    <= 32'd0;
         pix1_q    <= 32'd0;
         size0_q   <= 6'd0;
         size1_q   <= 6'd0;
      end else begin
         ready_q <= 1'b1;
         vprev_q <= v_active;
         dirty_q <= dirty_d;
         if (w_clear) tgt_q <= bus.in_data[1:0];
         if (w_done) begin
            case (tgt_q)
               TGT_PIX0:  shpix0_q  <= w_word;
               TGT_PIX1:  shpix1_q  <= w_word;
               TGT_SIZE0: shsize0_q <= bus.in_data[5:0];
               TGT_SIZE1: shsize1_q <= bus.in_data[5:0];
            endcase
         end
         if (w_commit) begin
            pix0_q  <= shpix0_q;
            pix1_q  <= shpix1_q;
            size0_q <= shsize0_q;
            size1_q <= shsize1_q;
         end
      end
   end

   assign bus.in_ready = ready_q;
   assign bg_pixels_0  = pix0_q;
   assign bg_pixels_1  = pix1_q;
   assign bg_size_0    = size0_q;
   assign bg_size_1    = size1_q;
   assign pending      = dirty_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_bg_loader.sv
`default_nettype none
// =============================================================================
// tb_vga_bg_loader : directed packet scenarios plus random traffic, checked
// against a packet-level reference model. Revision 1.0
// =============================================================================
module tb_vga_bg_loader;
   logic clk = 1'b0;
   logic rst_n;
   logic v_active;
   logic [31:0] bg_pixels_0, bg_pixels_1;
   logic [5:0]  bg_size_0, bg_size_1;
   logic        pending;

   vga_bg_loader_if bus ();

   vga_bg_loader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .v_active    (v_active),
      .bus         (bus),
      .bg_pixels_0 (bg_pixels_0),
      .bg_pixels_1 (bg_pixels_1),
      .bg_size_0   (bg_size_0),
      .bg_size_1   (bg_size_1),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
   endtask

   // Reference model: packet-level view of the loader
   bit          m_ready, m_vprev, m_inpkt, m_dirty;
   bit   [1:0]  m_tgt;
   int          m_n;
   logic [31:0] m_acc;
   logic [31:0] m_sh [4];
   logic [31:0] m_out[4];

   function automatic void model_step(input bit r, input bit v, input bit val, input logic [7:0] d);
      bit fire, wrote, commit_now;
      int need;
      if (!r) begin
         m_ready = 0; m_vprev = 0; m_inpkt = 0; m_dirty = 0; m_tgt = 0; m_n = 0; m_acc = 0;
         for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_out[i] = 0; end
         return;
      end
      fire  = val && m_ready;
      wrote = 0;
`ifdef VGA_BG_LOADER_VSYNC_COMMIT_EN
      commit_now = m_dirty && m_vprev && !v;
`else
      commit_now = m_dirty;
`endif
      if (commit_now) for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
      if (fire) begin
         if (!m_inpkt) begin
            if (d[7:2] == 6'd0) begin
               m_inpkt = 1; m_tgt = d[1:0]; m_n = 0; m_acc = 0;
            end
         end else begin
            m_acc = m_acc | (32'(d) << (8 * m_n));
            m_n++;
            need = (m_tgt >= 2) ? 1 : 4;
            if (m_n == need) begin
               m_sh[m_tgt] = (m_tgt >= 2) ? 32'(d[5:0]) : m_acc;
               wrote   = 1;
               m_inpkt = 0;
            end
         end
      end
      m_dirty = wrote ? 1'b1 : (commit_now ? 1'b0 : m_dirty);
      m_vprev = v;
      m_ready = 1;
   endfunction

   task automatic cmp_all();
      chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
      chk("pending",  32'(pending),      32'(m_dirty));
      chk("pix0",     bg_pixels_0,       m_out[0]);
      chk("pix1",     bg_pixels_1,       m_out[1]);
      chk("size0",    32'(bg_size_0),    m_out[2]);
      chk("size1",    32'(bg_size_1),    m_out[3]);
   endtask

   task automatic drive(input bit r, input bit v, input bit val, input logic [7:0] d);
      rst_n        = r;
      v_active     = v;
      bus.in_valid = val;
      bus.in_data  = d;
      @(posedge clk);
      model_step(r, v, val, d);
      #1;
      cmp_all();
   endtask

   task automatic send(input logic [7:0] d, input bit v);
      drive(1'b1, v, 1'b1, d);
   endtask

   task automatic vblank();
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      bit v;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_pix0", bg_pixels_0, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

      // Pixel word, LSB byte first, committed on the falling v_active
      send(8'h00, 1); send(8'h44, 1); send(8'h33, 1); send(8'h22, 1); send(8'h11, 1);
      chk("d1_pending", 32'(pending), 32'd1);
      chk("d1_pix0_old", bg_pixels_0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      chk("d1_pix0", bg_pixels_0, 32'h11223344);
      chk("d1_pending_clr", 32'(pending), 32'd0);

      send(8'h03, 1); send(8'hC5, 1); vblank();
      chk("d2_size1", 32'(bg_size_1), 32'h05);
      chk("d2_pix0_kept", bg_pixels_0, 32'h11223344);

      send(8'h84, 1);
      chk("d3_bad_hdr", 32'(pending), 32'd0);
      send(8'h02, 1); send(8'h07, 1); vblank();
      chk("d3_size0", 32'(bg_size_0), 32'd7);

      // Final byte on the vblank-start edge, with an earlier write still dirty
      send(8'h03, 1); send(8'h01, 1);
      send(8'h01, 1); send(8'hAA, 1); send(8'hBB, 1); send(8'hCC, 1);
      send(8'hDD, 0);
      chk("d4_pix1_old", bg_pixels_1, 32'd0);
      chk("d4_size1", 32'(bg_size_1), 32'd1);
      chk("d4_pending", 32'(pending), 32'd1);
      vblank();
      chk("d4_pix1", bg_pixels_1, 32'hDDCCBBAA);

      // Reset mid-packet
      send(8'h00, 1); send(8'h12, 1); send(8'h34, 1);
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      chk("d5_pix1_rst", bg_pixels_1, 32'd0);
      chk("d5_size0_rst", 32'(bg_size_0), 32'd0);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      send(8'h02, 1); send(8'h09, 1); vblank();
      chk("d5_size0", 32'(bg_size_0), 32'd9);

`ifdef VGA_BG_LOADER_VSYNC_COMMIT_EN
      // Outputs held for the whole active region
      send(8'h00, 1); send(8'h04, 1); send(8'h03, 1); send(8'h02, 1); send(8'h01, 1);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      chk("d6_pix0_held", bg_pixels_0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      chk("d6_pix0", bg_pixels_0, 32'h01020304);
`else
      send(8'h00, 1); send(8'h04, 1); send(8'h03, 1); send(8'h02, 1); send(8'h01, 1);
      chk("d6_pending", 32'(pending), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      chk("d6_pix0", bg_pixels_0, 32'h01020304);
      chk("d6_pending_clr", 32'(pending), 32'd0);
`endif

      // Random traffic
      v = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] d;
         bit r, val;
         if ($urandom_range(0, 7) == 0) v = ~v;
         r   = ($urandom_range(0, 249) != 0);
         val = ($urandom_range(0, 9) < 7);
         d   = 8'($urandom);
         if ($urandom_range(0, 1) == 0) d[7:2] = 6'd0;
         drive(r, v, val, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
